// File: rtl/ball_datapath_if.sv
// Ball control/status bundle between the control FSM (master) and the datapath (slave).
// Latency: wires only, no registers.
// Backpressure: none; move_tick is a strobe and sw is a one-cycle pulse. Score fields need BALL_SCORE_EN.
interface ball_datapath_if;
    logic       move_tick;
    logic [3:0] cw_ballMovement;
    logic [9:0] paddle_left_y;
    logic [9:0] paddle_right_y;
    logic [3:0] sw_ballMovement;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       serving;
`ifdef BALL_SCORE_EN
    logic [3:0] score_left;
    logic [3:0] score_right;

    modport master (
        output move_tick, cw_ballMovement, paddle_left_y, paddle_right_y,
        input  sw_ballMovement, ball_x, ball_y, serving, score_left, score_right
    );
    modport slave (
        input  move_tick, cw_ballMovement, paddle_left_y, paddle_right_y,
        output sw_ballMovement, ball_x, ball_y, serving, score_left, score_right
    );
`else
    modport master (
        output move_tick, cw_ballMovement, paddle_left_y, paddle_right_y,
        input  sw_ballMovement, ball_x, ball_y, serving
    );
    modport slave (
        input  move_tick, cw_ballMovement, paddle_left_y, paddle_right_y,
        output sw_ballMovement, ball_x, ball_y, serving
    );
`endif
endinterface

// File: rtl/ball_datapath.sv
// Ball position datapath: steps the ball on move_tick, reports paddle/border/miss events as set-word pulses.
// Latency: a step taken on clk N shows position and sw at N+1; sw returns to 0000 at N+2.
// Backpressure: none; cw is sampled every clk and serve (0101) overrides any step. Scores need BALL_SCORE_EN.
module ball_datapath #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int BALL_SIZE      = 8,
    parameter int PADDLE_L_X     = 16,
    parameter int PADDLE_R_X     = 616,
    parameter int PADDLE_W       = 8,
    parameter int PADDLE_H       = 64,
    parameter int TICKS_PER_STEP = 1,
    parameter int SERVE_TICKS    = 60
) (
    input  logic           clk,
    input  logic           reset,
    ball_datapath_if.slave bus
);
    localparam logic [9:0]  CX       = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  CY       = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  PL_HIT_X = 10'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] PR_HIT_X = 11'(PADDLE_R_X);
    localparam logic [10:0] BS11     = 11'(BALL_SIZE);
    localparam logic [10:0] PH11     = 11'(PADDLE_H);
    localparam logic [3:0]  DIV_LAST = 4'(TICKS_PER_STEP - 1);
    localparam int          SC_W     = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);
    localparam logic [SC_W-1:0] SERVE_LOAD = SC_W'(SERVE_TICKS);

    localparam logic [3:0] CW_PXPY  = 4'b0001;
    localparam logic [3:0] CW_NXNY  = 4'b0010;
    localparam logic [3:0] CW_NXPY  = 4'b0011;
    localparam logic [3:0] CW_PXNY  = 4'b0100;
    localparam logic [3:0] CW_SERVE = 4'b0101;

    localparam logic [3:0] SW_NONE  = 4'b0000;
    localparam logic [3:0] SW_HIT_R = 4'b0001;
    localparam logic [3:0] SW_HIT_L = 4'b0010;
    localparam logic [3:0] SW_TOP   = 4'b0011;
    localparam logic [3:0] SW_BOT   = 4'b0100;
    localparam logic [3:0] SW_MISS  = 4'b0101;

    logic [9:0]      ball_x;
    logic [9:0]      ball_y;
    logic [3:0]      sw;
    logic            serving;
    logic [SC_W-1:0] serve_cnt;
    logic [3:0]      tick_div;

    logic            mv_px, mv_nx, mv_py, mv_ny;
    logic [9:0]      x_nxt, y_nxt;
    logic [10:0]     y_ext;
    logic            ovl_l, ovl_r;
    logic [3:0]      evt;
    logic            do_step;

    // Decode the commanded direction; undefined codes move nowhere and raise no events.
    always_comb begin
        mv_px = 1'b0;
        mv_nx = 1'b0;
        mv_py = 1'b0;
        mv_ny = 1'b0;
        case (bus.cw_ballMovement)
            CW_PXPY: begin mv_px = 1'b1; mv_py = 1'b1; end
            CW_NXNY: begin mv_nx = 1'b1; mv_ny = 1'b1; end
            CW_NXPY: begin mv_nx = 1'b1; mv_py = 1'b1; end
            CW_PXNY: begin mv_px = 1'b1; mv_ny = 1'b1; end
            default: ;
        endcase
    end

    // Candidate position one pixel along the direction, saturated at the screen edges.
    always_comb begin
        x_nxt = ball_x;
        y_nxt = ball_y;
        if (mv_px && ball_x < X_MAX)
            x_nxt = ball_x + 10'd1;
        else if (mv_nx && ball_x != 10'd0)
            x_nxt = ball_x - 10'd1;
        if (mv_py && ball_y < Y_MAX)
            y_nxt = ball_y + 10'd1;
        else if (mv_ny && ball_y != 10'd0)
            y_nxt = ball_y - 10'd1;
    end

    // Vertical overlap with each paddle, widened to 11 bits so top+height cannot wrap.
    assign y_ext = {1'b0, y_nxt};
    assign ovl_l = ((y_ext + BS11) > {1'b0, bus.paddle_left_y}) &&
                   (y_ext < ({1'b0, bus.paddle_left_y} + PH11));
    assign ovl_r = ((y_ext + BS11) > {1'b0, bus.paddle_right_y}) &&
                   (y_ext < ({1'b0, bus.paddle_right_y} + PH11));

    // Classify the post-step position; earlier branches win when several apply.
    always_comb begin
        evt = SW_NONE;
        if ((mv_nx && x_nxt == 10'd0) || (mv_px && x_nxt == X_MAX))
            evt = SW_MISS;
        else if (mv_nx && x_nxt == PL_HIT_X && ovl_l)
            evt = SW_HIT_L;
        else if (mv_px && ({1'b0, x_nxt} + BS11) == PR_HIT_X && ovl_r)
            evt = SW_HIT_R;
        else if (mv_ny && y_nxt == 10'd0)
            evt = SW_TOP;
        else if (mv_py && y_nxt == Y_MAX)
            evt = SW_BOT;
    end

    assign do_step = bus.move_tick && !serving && (tick_div == DIV_LAST) &&
                     (bus.cw_ballMovement != CW_SERVE);

    // Position, serve hold, tick divider and the one-cycle event pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_x    <= CX;
            ball_y    <= CY;
            sw        <= SW_NONE;
            serving   <= 1'b1;
            serve_cnt <= SERVE_LOAD;
            tick_div  <= 4'd0;
        end else if (bus.cw_ballMovement == CW_SERVE) begin
            ball_x    <= CX;
            ball_y    <= CY;
            sw        <= SW_NONE;
            serving   <= 1'b1;
            serve_cnt <= SERVE_LOAD;
            tick_div  <= 4'd0;
        end else begin
            sw <= SW_NONE;
            if (bus.move_tick && serving) begin
                if (serve_cnt == '0 || serve_cnt == SC_W'(1)) begin
                    serve_cnt <= '0;
                    serving   <= 1'b0;
                end else begin
                    serve_cnt <= serve_cnt - SC_W'(1);
                end
            end
            if (do_step) begin
                tick_div <= 4'd0;
                ball_x   <= x_nxt;
                ball_y   <= y_nxt;
                sw       <= evt;
            end else if (bus.move_tick && !serving) begin
                tick_div <= tick_div + 4'd1;
            end
        end
    end

    assign bus.sw_ballMovement = sw;
    assign bus.ball_x          = ball_x;
    assign bus.ball_y          = ball_y;
    assign bus.serving         = serving;

`ifdef BALL_SCORE_EN
    logic [3:0] score_left;
    logic [3:0] score_right;

    // A miss at the left wall scores for the right player and vice versa; decimal wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_left  <= 4'd0;
            score_right <= 4'd0;
        end else if (do_step && evt == SW_MISS) begin
            if (x_nxt == 10'd0)
                score_right <= (score_right == 4'd9) ? 4'd0 : score_right + 4'd1;
            else
                score_left  <= (score_left == 4'd9) ? 4'd0 : score_left + 4'd1;
        end
    end

    assign bus.score_left  = score_left;
    assign bus.score_right = score_right;
`endif
endmodule

// File: tb/tb_ball_datapath.sv
// Bench for ball_datapath: directed navigation of the ball across the screen with a
// spec-level reference model compared every cycle, plus hand-computed pinned values.
module tb_ball_datapath;
    localparam int ST  = 4;
    localparam int TPS = 1;
    localparam int XM  = 632;
    localparam int YM  = 472;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_datapath_if bus();

    ball_datapath #(.SERVE_TICKS(ST), .TICKS_PER_STEP(TPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_ok  = 1'b0;

    typedef struct packed {
        int x; int y; int sw; int serving; int cnt; int div; int sl; int sr;
    } mst_t;
    mst_t m;

    // Reference behaviour for one clock, written from the rules in plain integer arithmetic.
    function automatic mst_t mnext(mst_t s, logic rst, logic mt, logic [3:0] cw, int ply, int pry);
        mst_t n = s;
        int dx = 0;
        int dy = 0;
        int nx;
        int ny;
        n.sw = 0;
        if (rst) begin
            n.x = 316; n.y = 236; n.serving = 1; n.cnt = ST; n.div = 0; n.sl = 0; n.sr = 0;
            return n;
        end
        if (cw == 4'b0101) begin
            n.x = 316; n.y = 236; n.serving = 1; n.cnt = ST; n.div = 0;
            return n;
        end
        if (!mt) return n;
        if (s.serving != 0) begin
            n.cnt = (s.cnt > 0) ? s.cnt - 1 : 0;
            if (n.cnt == 0) n.serving = 0;
            return n;
        end
        if (s.div != TPS - 1) begin
            n.div = s.div + 1;
            return n;
        end
        n.div = 0;
        case (cw)
            4'b0001: begin dx =  1; dy =  1; end
            4'b0010: begin dx = -1; dy = -1; end
            4'b0100: begin dx =  1; dy = -1; end
            4'b0011: begin dx = -1; dy =  1; end
            default: begin dx =  0; dy =  0; end
        endcase
        nx = s.x + dx;
        ny = s.y + dy;
        if (nx < 0) nx = 0;
        if (nx > XM) nx = XM;
        if (ny < 0) ny = 0;
        if (ny > YM) ny = YM;
        n.x = nx;
        n.y = ny;
        if ((dx < 0 && nx == 0) || (dx > 0 && nx == XM))                    n.sw = 5;
        else if (dx < 0 && nx == 24 && ny + 8 > ply && ny < ply + 64)        n.sw = 2;
        else if (dx > 0 && nx + 8 == 616 && ny + 8 > pry && ny < pry + 64)   n.sw = 1;
        else if (dy < 0 && ny == 0)                                          n.sw = 3;
        else if (dy > 0 && ny == YM)                                         n.sw = 4;
        if (n.sw == 5) begin
            if (nx == 0) n.sr = (s.sr + 1) % 10;
            else         n.sl = (s.sl + 1) % 10;
        end
        return n;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Pin both the DUT and the model to a hand-computed literal.
    task automatic pin(input string name, input int dut_v, input int mdl_v, input int lit);
        check(name, dut_v, lit);
        check({name, "/model"}, mdl_v, lit);
    endtask

    task automatic pulse(input int k);
        for (int i = 0; i < k; i++) begin
            repeat (2) @(negedge clk);
            bus.move_tick = 1'b1;
            @(negedge clk);
            bus.move_tick = 1'b0;
        end
    endtask

    task automatic pin_pos(input string name, input int x, input int y, input int sw);
        pin({name, ".x"},  int'(bus.ball_x),          m.x,  x);
        pin({name, ".y"},  int'(bus.ball_y),          m.y,  y);
        pin({name, ".sw"}, int'(bus.sw_ballMovement), m.sw, sw);
    endtask

    // Advance the model on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        m <= mnext(m, reset, bus.move_tick, bus.cw_ballMovement,
                   int'(bus.paddle_left_y), int'(bus.paddle_right_y));
        if (reset) mdl_ok <= 1'b1;
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mdl_ok) begin
            check("cyc.x",       int'(bus.ball_x),          m.x);
            check("cyc.y",       int'(bus.ball_y),          m.y);
            check("cyc.sw",      int'(bus.sw_ballMovement), m.sw);
            check("cyc.serving", int'(bus.serving),         m.serving);
`ifdef BALL_SCORE_EN
            check("cyc.score_l", int'(bus.score_left),      m.sl);
            check("cyc.score_r", int'(bus.score_right),     m.sr);
`endif
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        reset              = 1'b1;
        bus.move_tick      = 1'b0;
        bus.cw_ballMovement = 4'b0010;
        bus.paddle_left_y  = 10'd300;
        bus.paddle_right_y = 10'd500;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pin_pos("reset", 316, 236, 0);
        pin("reset.serving", int'(bus.serving), m.serving, 1);

        // Serve hold: four ticks without motion, the fifth steps.
        pulse(4);
        pin_pos("serve4", 316, 236, 0);
        pin("serve4.serving", int'(bus.serving), m.serving, 0);
        pulse(1);
        pin_pos("serve5", 315, 235, 0);

        // Undefined direction code holds the ball.
        bus.cw_ballMovement = 4'b0000;
        pulse(1);
        pin_pos("undef_cw", 315, 235, 0);

        // Up-left to the top wall.
        bus.cw_ballMovement = 4'b0010;
        pulse(235);
        pin_pos("top", 80, 0, 3);
        @(negedge clk);
        pin("top.clear", int'(bus.sw_ballMovement), m.sw, 0);

        // Down-left into the left paddle.
        bus.cw_ballMovement = 4'b0011;
        bus.paddle_left_y   = 10'd20;
        pulse(56);
        pin_pos("hit_l", 24, 56, 2);

        // Paddle moved away: the ball reaches the left wall.
        bus.paddle_left_y = 10'd400;
        pulse(24);
        pin_pos("miss_l", 0, 80, 5);
`ifdef BALL_SCORE_EN
        pin("miss_l.score_r", int'(bus.score_right), m.sr, 1);
        pin("miss_l.score_l", int'(bus.score_left),  m.sl, 0);
`endif

        // Serve command recentres and beats a coincident tick.
        bus.cw_ballMovement = 4'b0101;
        pulse(1);
        pin_pos("serve_cmd", 316, 236, 0);
        pin("serve_cmd.serving", int'(bus.serving), m.serving, 1);

        // Corner: paddle and top wall on the same step, then clamped top.
        bus.cw_ballMovement = 4'b0010;
        bus.paddle_left_y   = 10'd0;
        pulse(ST + 1 + 235 + 56);
        pin_pos("corner", 24, 0, 2);
        bus.cw_ballMovement = 4'b0100;
        pulse(1);
        pin_pos("corner_next", 25, 0, 3);

        // Down-right: bottom wall, right paddle, then right wall.
        bus.cw_ballMovement = 4'b0001;
        bus.paddle_right_y  = 10'd440;
        pulse(472);
        pin_pos("bottom", 497, 472, 4);
        pulse(111);
        pin_pos("hit_r", 608, 472, 1);
        pulse(24);
        pin_pos("miss_r", 632, 472, 5);
`ifdef BALL_SCORE_EN
        pin("miss_r.score_l", int'(bus.score_left),  m.sl, 1);
        pin("miss_r.score_r", int'(bus.score_right), m.sr, 1);
`endif

        // Reset on the clock the miss pulse is visible.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pin_pos("rst_on_miss", 316, 236, 0);
        pin("rst_on_miss.serving", int'(bus.serving), m.serving, 1);
`ifdef BALL_SCORE_EN
        pin("rst_on_miss.score_l", int'(bus.score_left),  m.sl, 0);
        pin("rst_on_miss.score_r", int'(bus.score_right), m.sr, 0);
`endif

        // Reset partway through a serve restarts the full hold.
        bus.cw_ballMovement = 4'b0010;
        pulse(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse(ST);
        pin_pos("midserve", 316, 236, 0);
        pin("midserve.serving", int'(bus.serving), m.serving, 0);
        pulse(1);
        pin_pos("midserve_step", 315, 235, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
